// File: rtl/cordic_rotation_fixed.sv
// Iterative rotation-mode CORDIC: rotates (x_in, y_in) by theta_in and removes the CORDIC gain.
// One micro-rotation per clock; result and done are held until valid drops.
module cordic_rotation_fixed #(
   parameter int N               = 15,
   parameter int WORD_LENGTH     = 16,
   parameter int FRACTION_LENGTH = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid,
   input  logic [WORD_LENGTH-1:0] x_in,
   input  logic [WORD_LENGTH-1:0] y_in,
   input  logic [WORD_LENGTH-1:0] theta_in,
   output logic [WORD_LENGTH-1:0] x_out,
   output logic [WORD_LENGTH-1:0] y_out,
   output logic                   done
);

   localparam int WL = WORD_LENGTH;
   localparam int XW = WL + 3;
   localparam int ZW = WL + 1;
   localparam int PW = XW + 13;

   localparam logic signed [ZW-1:0] QTR  = ZW'(64'sd1 <<< (WL - 2));
   localparam logic signed [12:0]   KC   = 13'sh09B7;
   localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (WL - 1)) - 64'sd1);
   localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

   typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

   state_t               state_q;
   logic [4:0]           i_q;
   logic signed [XW-1:0] x_q, y_q, x_d, y_d, x_cap, y_cap, xin_ext, yin_ext, x_sh, y_sh;
   logic signed [ZW-1:0] z_q, z_d, z_cap, th_ext, atan_i;
   logic signed [PW-1:0] x_prod, y_prod;
   logic [WL-1:0]        x_out_q, y_out_q, x_sat, y_sat;
   logic                 done_q;

   function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] k);
      logic [15:0] v;
      case (k)
         5'd0:    v = 16'h2000;
         5'd1:    v = 16'h12E4;
         5'd2:    v = 16'h09FB;
         5'd3:    v = 16'h0511;
         5'd4:    v = 16'h028B;
         5'd5:    v = 16'h0146;
         5'd6:    v = 16'h00A3;
         5'd7:    v = 16'h0051;
         5'd8:    v = 16'h0029;
         5'd9:    v = 16'h0014;
         5'd10:   v = 16'h000A;
         5'd11:   v = 16'h0005;
         5'd12:   v = 16'h0003;
         5'd13:   v = 16'h0001;
         5'd14:   v = 16'h0001;
         default: v = 16'h0000;
      endcase
      return ZW'(v);
   endfunction

   function automatic logic [WL-1:0] sat(input logic signed [PW-1:0] v);
      logic signed [PW-1:0] s;
      s = v >>> FRACTION_LENGTH;
      if (s > MAXV)      return WL'(MAXV);
      else if (s < MINV) return WL'(MINV);
      else               return WL'(s);
   endfunction

   // Fold angles beyond +/-90 deg into the CORDIC convergence range.
   always_comb begin
      xin_ext = XW'($signed(x_in));
      yin_ext = XW'($signed(y_in));
      th_ext  = ZW'($signed(theta_in));
      x_cap   = xin_ext;
      y_cap   = yin_ext;
      z_cap   = th_ext;
      if (th_ext > QTR) begin
         x_cap = -yin_ext;
         y_cap = xin_ext;
         z_cap = th_ext - QTR;
      end else if (th_ext < -QTR) begin
         x_cap = yin_ext;
         y_cap = -xin_ext;
         z_cap = th_ext + QTR;
      end
   end

   always_comb begin
      x_sh   = x_q >>> i_q;
      y_sh   = y_q >>> i_q;
      atan_i = atan_lut(i_q);
      if (!z_q[ZW-1]) begin
         x_d = x_q - y_sh;
         y_d = y_q + x_sh;
         z_d = z_q - atan_i;
      end else begin
         x_d = x_q + y_sh;
         y_d = y_q - x_sh;
         z_d = z_q + atan_i;
      end
      x_prod = PW'(x_q) * PW'(KC);
      y_prod = PW'(y_q) * PW'(KC);
      x_sat  = sat(x_prod);
      y_sat  = sat(y_prod);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         x_out_q <= '0;
         y_out_q <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (valid) begin
                  x_q     <= x_cap;
                  y_q     <= y_cap;
                  z_q     <= z_cap;
                  i_q     <= '0;
                  state_q <= ITER;
               end
            end
            ITER: begin
               if (!valid) begin
                  state_q <= IDLE;
               end else begin
                  x_q <= x_d;
                  y_q <= y_d;
                  z_q <= z_d;
                  i_q <= i_q + 5'd1;
                  if (i_q == 5'(N - 1)) state_q <= SCALE;
               end
            end
            SCALE: begin
               if (!valid) begin
                  state_q <= IDLE;
               end else begin
                  x_out_q <= x_sat;
                  y_out_q <= y_sat;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               if (!valid) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign x_out = x_out_q;
   assign y_out = y_out_q;
   assign done  = done_q;

endmodule

// File: tb/tb_cordic_rotation_fixed.sv
// Bench for cordic_rotation_fixed: fixed vectors, abort/reset sequences, random rotations
// and round-trip vectors, all compared against ideal trigonometry within an LSB tolerance.
module tb_cordic_rotation_fixed;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] x_in = '0, y_in = '0, theta_in = '0;
   logic [15:0] x_out, y_out;
   logic        done;

   int checks = 0;
   int failures = 0;

   localparam real PI = 3.14159265358979323846;

   always #5 clk = ~clk;

   cordic_rotation_fixed #(.N(15), .WORD_LENGTH(16), .FRACTION_LENGTH(12)) dut (
      .clk(clk), .rst(rst), .valid(valid),
      .x_in(x_in), .y_in(y_in), .theta_in(theta_in),
      .x_out(x_out), .y_out(y_out), .done(done)
   );

   typedef struct {
      logic [15:0] x, y, th;
      int ex, ey, tx, ty;
   } vec_t;

   vec_t vt[7];

   task automatic check(input string nm, input int act, input int exp, input int tol);
      checks++;
      if (act > exp + tol || act < exp - tol) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, exp, tol);
      end
   endtask

   function automatic int rnd_sat(input real r);
      int v;
      v = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      return v;
   endfunction

   // Ideal rotation of the input vector by the binary angle.
   task automatic ideal(input int xi, input int yi, input int th, output int ex, output int ey);
      real a;
      a  = $itor(th) * PI / 32768.0;
      ex = rnd_sat($itor(xi) * $cos(a) - $itor(yi) * $sin(a));
      ey = rnd_sat($itor(xi) * $sin(a) + $itor(yi) * $cos(a));
   endtask

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // Start an operation, scramble the inputs after capture, wait for done (bounded).
   task automatic run_op(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] th,
                         output int lat);
      @(negedge clk);
      x_in = xi; y_in = yi; theta_in = th; valid = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 40) begin
         x_in = 16'($urandom); y_in = 16'($urandom); theta_in = 16'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      if (!done) begin
         failures++;
         $display("FAIL timeout: done not seen after %0d edges", lat);
      end
   endtask

   task automatic drop_valid();
      @(negedge clk);
      valid = 1'b0;
   endtask

   initial begin
      int lat, ex, ey, xi, yi, tv, mag;
      logic [15:0] th;
      bit sawdone;

      vt[0] = '{16'h1000, 16'h0000, 16'h2000,  2896,  2896, 4, 4};
      vt[1] = '{16'h1000, 16'h0000, 16'h4000,     0,  4096, 4, 4};
      vt[2] = '{16'h1000, 16'h0000, 16'h6000, -2896,  2896, 4, 4};
      vt[3] = '{16'h1000, 16'h0000, 16'h8000, -4096,     0, 4, 4};
      vt[4] = '{16'h0000, 16'h1000, 16'hE000,  2896,  2896, 4, 4};
      // Full-scale magnitude amplifies the residual angle quantisation on x.
      vt[5] = '{16'h7FFF, 16'h7FFF, 16'h2000,     0, 32767, 8, 0};
      vt[6] = '{16'h1000, 16'h0000, 16'hC000,     0, -4096, 4, 4};

      #1;
      check("reset_x", sx(x_out), 0, 0);
      check("reset_y", sx(y_out), 0, 0);
      check("reset_done", int'(done), 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_op(vt[i].x, vt[i].y, vt[i].th, lat);
         check($sformatf("tbl%0d_latency", i), lat, 16, 0);
         check($sformatf("tbl%0d_x", i), sx(x_out), vt[i].ex, vt[i].tx);
         check($sformatf("tbl%0d_y", i), sx(y_out), vt[i].ey, vt[i].ty);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("tbl%0d_done_hold", i), int'(done), 1, 0);
         check($sformatf("tbl%0d_x_hold", i), sx(x_out), vt[i].ex, vt[i].tx);
         drop_valid();
         @(posedge clk); #1;
         check($sformatf("tbl%0d_done_fall", i), int'(done), 0, 0);
      end

      // Abort at iteration 5: outputs keep the previous (-90 deg) result.
      @(negedge clk);
      x_in = 16'h0800; y_in = 16'h0300; theta_in = 16'h1234; valid = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      sawdone = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) sawdone = 1'b1;
      end
      check("abort_done", int'(sawdone), 0, 0);
      check("abort_x", sx(x_out), 0, 4);
      check("abort_y", sx(y_out), -4096, 4);

      // Reset mid-ITER clears everything immediately.
      @(negedge clk);
      x_in = 16'h1000; y_in = 16'h0000; theta_in = 16'h2000; valid = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_x", sx(x_out), 0, 0);
      check("midrst_y", sx(y_out), 0, 0);
      check("midrst_done", int'(done), 0, 0);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_op(16'h1000, 16'h0000, 16'h2000, lat);
      check("post_rst_latency", lat, 16, 0);
      check("post_rst_x", sx(x_out), 2896, 4);
      check("post_rst_y", sx(y_out), 2896, 4);
      drop_valid();

      // Random rotations of vectors within unit magnitude.
      for (int k = 0; k < 60; k++) begin
         xi = int'($urandom_range(5792, 0)) - 2896;
         yi = int'($urandom_range(5792, 0)) - 2896;
         th = 16'($urandom);
         ideal(xi, yi, sx(th), ex, ey);
         run_op(16'(xi), 16'(yi), th, lat);
         check($sformatf("rnd%0d_x", k), sx(x_out), ex, 4);
         check($sformatf("rnd%0d_y", k), sx(y_out), ey, 4);
         drop_valid();
      end

      // Round trip: rotating by minus the vector's own angle lands it on +x.
      for (int k = 0; k < 100; k++) begin
         xi  = int'($urandom_range(5792, 0)) - 2896;
         yi  = int'($urandom_range(5792, 0)) - 2896;
         tv  = rnd_sat($atan2($itor(yi), $itor(xi)) * 32768.0 / PI);
         th  = 16'(-tv);
         mag = rnd_sat($sqrt($itor(xi * xi + yi * yi)));
         run_op(16'(xi), 16'(yi), th, lat);
         check($sformatf("rt%0d_x", k), sx(x_out), mag, 6);
         check($sformatf("rt%0d_y", k), sx(y_out), 0, 6);
         drop_valid();
      end

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cordic_rotation_fixed.md
Name: cordic_rotation_fixed

Overview:
Iterative fixed-point CORDIC in rotation mode. It rotates the input vector (x_in, y_in) by the angle theta_in and returns the gain-compensated rotated vector.
- It is the counterpart of the vectoring CORDIC in the matrix-inversion datapath: the vectoring unit produces Givens angles, and this block applies them to the remaining matrix rows.
- Angle format and valid/done handshake match the vectoring unit, so its theta output feeds theta_in directly.

Parameters:
N, 15, number of micro-rotation iterations (1..16)
WORD_LENGTH, 16, width of data/angle ports
FRACTION_LENGTH, 12, fractional bits of x/y data (Q3.12 at default)

Ports:
clk  in  1  clock
rst  in  1  reset
valid  in  1  request; held high for the whole operation
x_in  in  WORD_LENGTH  signed x component, Q(WL-FL-1).FL
y_in  in  WORD_LENGTH  signed y component, same format
theta_in  in  WORD_LENGTH  signed binary angle, 0x2000 = +45 deg, 0x4000 = +90 deg, 0x8000 = -180 deg
x_out  out  WORD_LENGTH  rotated, gain-compensated x
y_out  out  WORD_LENGTH  rotated, gain-compensated y
done  out  1  result valid; held while valid stays high

Interface (already decided): reset rst, asynchronous, active-low; clock clk.

Behaviour:
- Reset (rst=0, asynchronous): x_out=0, y_out=0, done=0, state=IDLE, iteration counter i=0, internal x/y/z=0.
- Internal registers: x,y signed WORD_LENGTH+3 bits; z signed WORD_LENGTH+1 bits; all inputs sign-extended before any arithmetic.
- States: IDLE, ITER, SCALE, DONE.
- IDLE: on a clock edge with valid=1, capture inputs with quadrant pre-rotation, set i=0, go to ITER. done stays 0.
- Pre-rotation at capture:
  - theta_in > 0x4000: x=-y_in, y=x_in, z=theta_in-0x4000.
  - theta_in < -0x4000 (includes 0x8000): x=y_in, y=-x_in, z=theta_in+0x4000.
  - Otherwise: x=x_in, y=y_in, z=theta_in.
- ITER: one micro-rotation per clock, using arithmetic shifts and the old x/y values.
  - If z >= 0: x <= x-(y>>>i), y <= y+(x>>>i), z <= z-atan[i].
  - Else: x <= x+(y>>>i), y <= y-(x>>>i), z <= z+atan[i].
  - i <= i+1. Leave to SCALE after the iteration with i=N-1.
- atan table: atan[i] = round(atan(2^-i) * 32768/pi).
  - i=0..11: 0x2000, 0x12E4, 0x09FB, 0x0511, 0x028B, 0x0146, 0x00A3, 0x0051, 0x0029, 0x0014, 0x000A, 0x0005.
  - i=12..15: 3, 1, 1, 0.
- SCALE: x_out <= sat((x*K)>>>FRACTION_LENGTH), y_out likewise.
  - K = 0x09B7 (0.60725 in Q.FL), signed multiply at full width.
  - sat clamps to [-2^(WL-1), 2^(WL-1)-1].
  - done <= 1, go to DONE.
- Latency: done rises on the (N+1)th rising edge after the capture edge (16 edges at N=15).
- DONE: outputs and done held stable while valid=1. When valid=0: done <= 0, go to IDLE. A new operation needs valid low for at least one edge; there is no auto-restart.
- valid=0 during ITER or SCALE: abort, go to IDLE, done=0, x_out/y_out keep their previous values.
- Input changes after capture are ignored until the next IDLE capture.
- Reset mid-operation: immediate return to reset values.
- Accuracy target: |error| <= 4 LSB per output for in-range results (|x|,|y| <= 1.0 scaled magnitude, non-saturating).

Test Plan:
- x_in=0x1000, y_in=0, theta_in=0x2000 -> after 16 edges done=1, x_out ~ y_out ~ 0x0B50 (2896) +/-4.
- x_in=0x1000, y_in=0, theta_in=0x4000, then 0x6000, then 0x8000 (valid dropped between runs) -> results (0, 4096), (-2896, 2896), (-4096, 0), each +/-4. Checks pre-rotation at the boundary and above it.
- x_in=0, y_in=0x1000, theta_in=0xE000 (-45 deg) -> x_out ~ 2896, y_out ~ 2896. Also check done held while valid high and falling one edge after valid drops.
- x_in=0x7FFF, y_in=0x7FFF, theta_in=0x2000 -> y_out=0x7FFF (saturated), |x_out| <= 4.
- Abort and reset: valid dropped at iteration 5 -> done never asserts and outputs are unchanged. rst pulsed low mid-ITER -> all outputs 0 immediately. A following full request completes normally.
- Round trip: feed the vectoring unit's theta output (negated) plus the original vector -> y_out ~ 0 and x_out ~ vector magnitude +/-6 LSB, across 100 random vectors.
